// File: rtl/cfg_bank_writer.sv
// Configuration bank writer: assembles BL_WIDTH-bit rows from a word stream and pulses one wordline per row.
// Optional per-row parity word and row skip on mismatch: define CFG_PARITY_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, bl_out holds last row
// S_LOAD  | accepting row words into bl_out
// S_CHECK | accepting the row parity word (CFG_PARITY_EN only)
// S_SETUP | bl_out settled, wordlines low
// S_PULSE | wordline of the current row high for WL_PULSE cycles
// S_HOLD  | wordlines low, bl_out held, then next row or finish
// S_DONE  | one-cycle done pulse
module cfg_bank_writer #(
   parameter int BL_WIDTH   = 315,
   parameter int WL_WIDTH   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int WL_PULSE   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [BL_WIDTH-1:0]   bl_out,
   output logic [WL_WIDTH-1:0]   wl_out,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int WORDS = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int RW    = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
   localparam int PW    = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
   localparam int BBW   = $clog2(WORDS * DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
`ifdef CFG_PARITY_EN
      S_CHECK,
`endif
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [WCW-1:0]      word_cnt;
   logic [RW-1:0]       row;
   logic [PW-1:0]       pulse_cnt;
   logic [WL_WIDTH-1:0] wl_nxt;
   logic                row_bad;
   logic                accept;
   logic                last_word;
   logic                last_row;
   logic [BBW-1:0]      bit_base;
   logic [BL_WIDTH-1:0] wr_mask;
   logic [BL_WIDTH-1:0] wr_data;

`ifdef CFG_PARITY_EN
   assign data_ready = (state == S_LOAD) || (state == S_CHECK);
`else
   assign data_ready = (state == S_LOAD);
`endif
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);
   assign accept    = data_valid && data_ready;
   assign last_word = (word_cnt == WCW'(WORDS - 1));
   assign last_row  = (row == RW'(WL_WIDTH - 1));

   // Word lanes beyond BL_WIDTH fall off the top of the shift and are dropped.
   assign bit_base = BBW'(word_cnt) * BBW'(DATA_WIDTH);
   assign wr_mask  = BL_WIDTH'({DATA_WIDTH{1'b1}}) << bit_base;
   assign wr_data  = BL_WIDTH'(data_in) << bit_base;

   always_comb begin
      state_nxt = state;
      wl_nxt    = '0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD: begin
            if (accept && last_word) begin
`ifdef CFG_PARITY_EN
               state_nxt = S_CHECK;
`else
               state_nxt = S_SETUP;
`endif
            end
         end
`ifdef CFG_PARITY_EN
         S_CHECK: if (accept) state_nxt = S_SETUP;
`endif
         S_SETUP: state_nxt = S_PULSE;
         S_PULSE: if (pulse_cnt == '0) state_nxt = S_HOLD;
         S_HOLD:  state_nxt = last_row ? S_DONE : S_LOAD;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Wordline is registered, so it is decoded from the state being entered.
      if ((state_nxt == S_PULSE) && !row_bad)
         wl_nxt = WL_WIDTH'(1) << row;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         word_cnt  <= '0;
         row       <= '0;
         pulse_cnt <= '0;
         bl_out    <= '0;
         wl_out    <= '0;
      end else begin
         state  <= state_nxt;
         wl_out <= wl_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  row      <= '0;
                  word_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  bl_out   <= (bl_out & ~wr_mask) | (wr_data & wr_mask);
                  word_cnt <= word_cnt + WCW'(1);
               end
            end
            S_SETUP: pulse_cnt <= PW'(WL_PULSE - 1);
            S_PULSE: if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - PW'(1);
            S_HOLD: begin
               if (!last_row) begin
                  row      <= row + RW'(1);
                  word_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CFG_PARITY_EN
   // error is sticky across rows; row_bad only suppresses the current row's pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         error   <= 1'b0;
         row_bad <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  error   <= 1'b0;
                  row_bad <= 1'b0;
               end
            end
            S_CHECK: begin
               if (accept && (data_in[0] != ^bl_out)) begin
                  error   <= 1'b1;
                  row_bad <= 1'b1;
               end
            end
            S_HOLD:  row_bad <= 1'b0;
            default: ;
         endcase
      end
   end
`else
   assign error   = 1'b0;
   assign row_bad = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_bank_writer.sv
// Randomized bench for cfg_bank_writer against a row-level reference model.
// Build with CFG_PARITY_EN defined to include the parity-row scenarios.
module tb_cfg_bank_writer;

   localparam int BL    = 315;
   localparam int WL    = 4;
   localparam int DW    = 8;
   localparam int WP    = 2;
   localparam int WORDS = 40;
`ifdef CFG_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int ROW_CYC = WORDS + PAR + 1 + WP + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          data_valid = 1'b0;
   logic          data_ready;
   logic [BL-1:0] bl_out;
   logic [WL-1:0] wl_out;
   logic          busy;
   logic          done;
   logic          error;

   cfg_bank_writer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .bl_out     (bl_out),
      .wl_out     (wl_out),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [BL-1:0] exp_row [WL];
   logic [DW-1:0] stream [$];
   bit            stop_run;

   task automatic chk(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Row image: bit j of word k lands at k*DW+j when that index exists.
   task automatic build(input bit pat_a5, input bit f8_last, input int bad_row);
      logic [BL-1:0] rb;
      logic [DW-1:0] w;
      stream.delete();
      for (int r = 0; r < WL; r++) begin
         rb = '0;
         for (int k = 0; k < WORDS; k++) begin
            w = pat_a5 ? 8'hA5 : 8'($urandom);
            if (f8_last && k == WORDS - 1) w = 8'hF8;
            stream.push_back(w);
            for (int j = 0; j < DW; j++)
               if (k * DW + j < BL) rb[k*DW+j] = w[j];
         end
         exp_row[r] = rb;
`ifdef CFG_PARITY_EN
         w = 8'($urandom);
         w[0] = (^rb) ^ (r == bad_row);
         stream.push_back(w);
`endif
      end
   endtask

   // mode 0: valid always high, 1: toggling, 2: random
   task automatic run_bank(input int mode, input int abort_row, input bit poke, input int bad_row);
      int            cyc, done_cyc, done_cnt, next_row, pops, t, idx;
      int            pulse_len [WL];
      bit            prev_v, prev_r, poked;
      logic [BL-1:0] bl_prev;
      logic [WL-1:0] wl_prev;
      stop_run = 1'b0;
      pops = 0; t = 0; poked = 1'b0;
      for (int r = 0; r < WL; r++) pulse_len[r] = 0;
      @(negedge clk);
      start      = 1'b1;
      data_valid = 1'b1;
      data_in    = stream[0];
      prev_v     = data_valid;
      prev_r     = data_ready;
      fork
         begin
            while (!stop_run) begin
               @(negedge clk);
               start = 1'b0;
               if (prev_v && prev_r && stream.size() > 0) begin
                  void'(stream.pop_front());
                  pops++;
               end
               t++;
               data_valid = (stream.size() > 0) &&
                            (mode == 0 || (mode == 1 && t % 2 == 1) ||
                             (mode == 2 && $urandom_range(0, 2) != 0));
               data_in = (stream.size() > 0) ? stream[0] : 8'h00;
               if (poke && !poked && pops == WORDS + PAR + 5) begin
                  start = 1'b1;
                  poked = 1'b1;
               end
               prev_v = data_valid;
               prev_r = data_ready;
            end
            data_valid = 1'b0;
            start      = 1'b0;
         end
         begin
            cyc = 0; done_cnt = 0; done_cyc = -1; next_row = 0; idx = 0;
            wl_prev = '0;
            bl_prev = bl_out;
            while (!stop_run) begin
               @(negedge clk);
               cyc++;
               if (cyc == 1) begin
                  chk("busy_first", busy, 1);
                  chk("ready_first", data_ready, 1);
               end
               chk("ready_ctx", data_ready & (~busy | (|wl_out) | done), 0);
               chk("wl_onehot", ($countones(wl_out) <= 1), 1);
               if (wl_out != '0) begin
                  chk("bl_stable", bl_out, bl_prev);
                  for (int b = 0; b < WL; b++) if (wl_out[b]) idx = b;
                  pulse_len[idx]++;
                  if (wl_prev == '0) begin
                     if (next_row == bad_row) next_row++;
                     chk("row_order", idx, next_row);
                     chk("bl_row", bl_out, exp_row[idx]);
                     if (bad_row >= 0 && idx > bad_row) chk("err_set", error, 1);
                     next_row = idx + 1;
                     if (idx == abort_row) begin
                        #2 reset = 1'b0;
                        #1;
                        chk("rst_wl", wl_out, 0);
                        chk("rst_bl", bl_out, 0);
                        chk("rst_busy", busy, 0);
                        chk("rst_ready", data_ready, 0);
                        chk("rst_done", done, 0);
                        chk("rst_err", error, 0);
                        stop_run = 1'b1;
                     end
                  end
               end
               if (done) begin
                  done_cnt++;
                  if (done_cyc < 0) done_cyc = cyc;
               end
               if (done_cyc > 0 && cyc >= done_cyc + 4) stop_run = 1'b1;
               if (cyc > 3000) begin
                  chk("timeout", done_cnt, 1);
                  stop_run = 1'b1;
               end
               bl_prev = bl_out;
               wl_prev = wl_out;
            end
         end
      join
      if (abort_row < 0) begin
         chk("done_once", done_cnt, 1);
         if (mode == 0) chk("done_cycle", done_cyc, 4 * ROW_CYC + 1);
         for (int r = 0; r < WL; r++)
            chk("pulse_len", pulse_len[r], (r == bad_row) ? 0 : WP);
         chk("busy_end", busy, 0);
         chk("error_end", error, (bad_row >= 0) ? 1 : 0);
         chk("stream_used", stream.size(), 0);
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      #1;
      chk("init_bl", bl_out, 0);
      chk("init_wl", wl_out, 0);
      chk("init_busy", busy, 0);
      chk("init_done", done, 0);
      chk("init_err", error, 0);
      chk("init_ready", data_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      build(1'b1, 1'b0, -1);
      run_bank(0, -1, 1'b0, -1);
      chk("a5_top", bl_out[314:312], 3'b101);

      build(1'b0, 1'b0, -1);
      run_bank(1, -1, 1'b0, -1);

      build(1'b0, 1'b0, -1);
      run_bank(2, -1, 1'b0, -1);

      build(1'b0, 1'b0, -1);
      run_bank(0, 2, 1'b0, -1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      build(1'b0, 1'b0, -1);
      run_bank(0, -1, 1'b1, -1);

      build(1'b0, 1'b1, -1);
      run_bank(0, -1, 1'b0, -1);
      chk("f8_top", bl_out[314:312], 3'b000);

`ifdef CFG_PARITY_EN
      build(1'b0, 1'b0, 1);
      run_bank(0, -1, 1'b0, 1);
      build(1'b0, 1'b0, -1);
      run_bank(2, -1, 1'b0, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cfg_bank_writer.md
# cfg_bank_writer

Bitline/wordline configuration writer that programs a tile's configuration memory bank. It accepts a bitstream on a valid/ready word stream, assembles one BL_WIDTH-bit row, and drives it on `bl_out`. It then pulses one wordline and repeats for all WL_WIDTH rows. It sits at the fabric edge and drives the `bl_in`/`wl_in` chain that tiles forward unchanged to their neighbours.

## Interface
- `BL_WIDTH`, 315: bitlines per row.
- `WL_WIDTH`, 4: wordlines, one per row.
- `DATA_WIDTH`, 8: stream word width.
- `WL_PULSE`, 2: wordline high time in cycles, ≥1.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `start` input 1: single-cycle request to program the whole bank.
- `data_in` input DATA_WIDTH: bitstream word.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: the block accepts a word this cycle.
- `bl_out` output BL_WIDTH: bitline drive, registered.
- `wl_out` output WL_WIDTH: wordline drive, one-hot or zero, registered.
- `busy` output 1: high from the cycle after `start` until `done`.
- `done` output 1: one-cycle pulse after the last row's HOLD.
- `error` output 1: sticky parity error flag. Stuck at 0 unless CFG_PARITY_EN is defined.

## Operation
- WORDS = ceil(BL_WIDTH/DATA_WIDTH); this is 40 with the defaults.
- A word is accepted when `data_valid` and `data_ready` are both high.
- Bit mapping: bit j of accepted word k of a row lands on `bl_out[k*DATA_WIDTH+j]`.
- Bits at index ≥ BL_WIDTH are discarded. With the defaults, bits 7:3 of word 39 are dropped.
- Rows are programmed in order: row 0 uses `wl_out[0]`, up to row WL_WIDTH-1.
- States:
  - IDLE: `start` → LOAD; row=0, word=0, `error` cleared.
  - LOAD: `data_ready`=1. Each accepted word is written into `bl_out` and increments word. Acceptance of word WORDS-1 → CHECK (if CFG_PARITY_EN) or SETUP.
  - CHECK: `data_ready`=1. Waits for one extra parity word and compares its bit0 against the XOR of all BL_WIDTH row bits. Mismatch sets `error`. On acceptance → SETUP.
  - SETUP: one cycle with `bl_out` stable and `wl_out`=0.
  - PULSE: `wl_out[row]`=1 for WL_PULSE cycles. If this row had a parity mismatch, `wl_out` stays 0 (the row is skipped).
  - HOLD: one cycle with `wl_out`=0 and `bl_out` held. If row<WL_WIDTH-1: row++, word=0 → LOAD. Otherwise → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `bl_out` holds its last value in IDLE and is overwritten word by word during the next LOAD.
- `start` is ignored whenever the state is not IDLE.
- A word presented while `data_ready`=0 is not consumed.
- If `start` and `data_valid` are high in the same cycle, no word is accepted that cycle.
- `data_valid` stalls mid-row leave state, word and `bl_out` frozen. There is no timeout.

## Timing
- Reset asserted (any state, including mid-PULSE) forces the following immediately, without waiting for `clk`:
  - `bl_out`=0, `wl_out`=0, `busy`=0, `done`=0, `error`=0, `data_ready`=0;
  - state=IDLE.
- Release of reset takes effect on the first `clk` edge at which `reset` is high.
- `data_ready` is decoded from the state register only. It never depends combinationally on `data_valid`.
- `start` at edge N: LOAD at N+1, so `data_ready` and `busy` are high in cycle N+1.
- Row length with full-rate `data_valid`: WORDS (+1 with CFG_PARITY_EN) + 1 + WL_PULSE + 1 cycles.
- Defaults, no parity: 44 cycles per row, 176 cycles total. `done` is high in cycle N+177.
- `wl_out` never has more than one bit set.
- `wl_out` is never high in the same cycle that `bl_out` changes.

## Configuration
- CFG_PARITY_EN:
  - Defined: the CHECK state exists, one parity word is consumed per row, a mismatching row has its wordline pulse suppressed, and `error` is sticky until the next `start`.
  - Undefined: CHECK does not exist, LOAD goes straight to SETUP, and `error` is tied to 0.

## Test plan
- Defaults, no parity:
  - Stimulus: `start`, then 160 words of 0xA5 with `data_valid` held high.
  - Required: `bl_out[314:0]` shows the 0xA5 pattern, with `bl_out[314:312]`=3'b101.
  - Required: `wl_out` reads 0001, 0010, 0100, 1000, each high exactly 2 cycles.
  - Required: `done` pulses exactly 177 cycles after the `start` edge.
- Throttled `data_valid`:
  - Stimulus: `data_valid` toggling every cycle.
  - Required: identical `bl_out`/`wl_out` sequence, with each row's LOAD stretched to 80 cycles.
  - Required: `data_ready` is never high outside LOAD/CHECK.
- Reset mid-operation:
  - Stimulus: `reset` driven low during row 2 PULSE.
  - Required: `wl_out`=0 and `bl_out`=0 immediately, with no clock edge.
  - Stimulus: a new `start` after release.
  - Required: programming restarts from row 0, word 0.
- Ignored `start`:
  - Stimulus: `start` pulsed again during LOAD of row 1.
  - Required: no state change, and `done` pulses exactly once.
- CFG_PARITY_EN defined:
  - Stimulus: row 1 given a wrong parity bit, all other rows correct.
  - Required: `wl_out[1]` never goes high and `error`=1 after row 1 CHECK.
  - Required: rows 0, 2 and 3 are pulsed normally, and total time is 4 cycles longer.
- Dropped bits:
  - Stimulus: last word of each row = 0xF8.
  - Required: `bl_out[314:312]`=0, with the upper 5 bits discarded and no spill into the next row.
